pipeline_hazard_controller: RTL

Central pipeline controller for the 5-stage ARM core. It detects RAW data hazards between the ID stage sources and in-flight EXE/MEM destinations, and produces the `hazard` input consumed by the decode stage. It sequences multi-cycle SRAM accesses from the MEM stage through a start/ready handshake, freezing the whole pipeline while an access is in flight. It also issues branch flushes and keeps a saturating stall counter for performance debug.

---
 rtl/pipeline_hazard_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Central pipeline controller: RAW hazard detection, SRAM access sequencing
// with freeze and timeout, branch flush, and a saturating stall counter.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 63,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             Two_src,
    input  logic [3:0]       EXE_Dest,
    input  logic             EXE_WB_EN,
    input  logic             EXE_MEM_R_EN,
    input  logic [3:0]       MEM_Dest,
    input  logic             MEM_WB_EN,
    input  logic             Forward_EN,
    input  logic             Branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic             sram_start,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic m1, m2, load_use, raw_hz;
    logic start_c, freeze_c, timeout_hit;

    // With forwarding, only a load in EXE cannot be bypassed in time.
    always_comb begin
        m1       = ((src1 == EXE_Dest) && EXE_WB_EN) || ((src1 == MEM_Dest) && MEM_WB_EN);
        m2       = Two_src && (((src2 == EXE_Dest) && EXE_WB_EN) || ((src2 == MEM_Dest) && MEM_WB_EN));
        load_use = EXE_MEM_R_EN && ((src1 == EXE_Dest) || (Two_src && (src2 == EXE_Dest)));
        raw_hz   = Forward_EN ? load_use : (m1 || m2);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        start_c     = 1'b0;
        freeze_c    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    start_c    = 1'b1;
                    freeze_c   = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                timeout_hit = !sram_ready && (wait_cnt_q == TIMEOUT_VAL);
                if (sram_ready) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    mem_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    freeze_c   = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Freeze dominates flush, flush dominates hazard.
    always_comb begin
        freeze      = freeze_c;
        flush       = Branch_taken && !freeze_c;
        hazard      = raw_hz && !flush && !freeze_c;
        sram_start  = start_c && !rst;
        stall_cnt_d = stall_cnt_q;
        if ((hazard || freeze_c) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_error   = mem_error_q;
    assign stall_count = stall_cnt_q;

endmodule
